maze_player_mover: RTL and testbench
====================================

Name: maze_player_mover

Overview:
- Movement engine that consumes the game-state code from the maze top-level state machine.
- Turns one-cycle direction key pulses into checked moves of the player position (my_x, my_y).
- Checks each target cell by reading one wall bit from the maze map RAM.
- Returns `arrived` to the state machine when the player reaches the exit cell.

Parameters:
- COORD_W, 9, width of the x/y coordinates and of the map size inputs.
- CNT_W, 16, width of the saturating move counter.

Ports:
- clk  in  1  system clock.
- rst_sys  in  1  synchronous reset, active-high.
- state  in  2  game state: 00 welcome, 01 ready, 10 playing, 11 finished.
- map_w  in  COORD_W  maze width in cells. Stable while state is 10. Legal range 3..511.
- map_h  in  COORD_W  maze height in cells. Same rules as map_w.
- key_up  in  1  one-cycle request pulse; key_up decrements y.
- key_down  in  1  one-cycle request pulse; key_down increments y.
- key_left  in  1  one-cycle request pulse; key_left decrements x.
- key_right  in  1  one-cycle request pulse; key_right increments x.
- rd_en  out  1  map read strobe, registered.
- rd_x  out  COORD_W  map read column, registered.
- rd_y  out  COORD_W  map read row, registered.
- wall  in  1  map data: 1 = wall. Valid exactly one cycle after rd_en is high.
- my_x  out  COORD_W  player column, registered.
- my_y  out  COORD_W  player row, registered.
- arrived  out  1  player is on the exit cell (level signal).
- busy  out  1  a move is in flight.
- move_cnt  out  CNT_W  number of accepted moves; saturates at all-ones.

Behaviour:
- Reset (rst_sys=1 at a clk edge) sets:
  - my_x=1, my_y=1
  - arrived=0, busy=0, rd_en=0, rd_x=0, rd_y=0, move_cnt=0
  - internal FSM to IDLE
  - reset mid-move discards the move and does not count it.
- Exit cell: (map_w-2, map_h-2).
- While state is 00 or 01:
  - my_x and my_y are forced to 1 every cycle, FSM forced to IDLE, rd_en=0, busy=0.
  - In state 01, move_cnt is cleared to 0. In state 00 it holds.
- While state is 11: position and move_cnt freeze, keys are ignored, FSM goes to IDLE.
- Internal FSM has two states, IDLE and WAIT.
- IDLE, when state==10 and at least one key is high at edge t:
  - Take exactly one direction by priority up > down > left > right.
  - Compute the target cell.
  - Border check: reject the move (stay IDLE, no read, no count) if any of these holds:
    - up with my_y==0
    - down with my_y>=map_h-1
    - left with my_x==0
    - right with my_x>=map_w-1
  - Otherwise at edge t: rd_x/rd_y <= target, rd_en <= 1, busy <= 1, FSM goes to WAIT.
- WAIT (during cycle t+1):
  - rd_en <= 0 at edge t+1.
  - At edge t+2, wall is sampled:
    - wall==0: my_x/my_y <= target and move_cnt increments (unless saturated).
    - wall==1: position unchanged, no count.
  - busy <= 0 at edge t+2; FSM returns to IDLE.
- Key-to-position latency is 2 cycles. At most one move every 2 cycles.
- Keys arriving while busy==1 are dropped, not queued.
- If state leaves 10 while in WAIT, the pending move is discarded and the state-specific rules above apply.
- arrived is registered. It is updated every cycle to (state==10 or state==11) and my_x==map_w-2 and my_y==map_h-2, evaluated on the position being written that cycle.
  - So arrived rises on the same edge as the final move.
  - It is low in states 00 and 01.
- Coordinate arithmetic is unsigned, COORD_W bits. Because of the border check, no wrap-around can occur.

Test Plan:
- Reset, then state=01 -> my_x=my_y=1, arrived=0, busy=0, move_cnt=0, rd_en never asserted.
- map 7x7, state=10, key_right pulse at edge t, wall=0 -> rd_en high for one cycle with rd_x=2, rd_y=1; my_x=2 after edge t+2; move_cnt=1; busy high for exactly 2 cycles.
- From (1,1), key_down with wall=1 -> rd_y=2 read issued; position stays (1,1), move_cnt unchanged. Then key_up at my_y=0 (position forced by prior moves) -> no rd_en, no change.
- key_up+key_left asserted in the same cycle -> only the up move is read. A key_right pulse at t+1 (busy) is ignored; no second rd_en.
- map 7x7: walk with wall=0 to (5,5) -> arrived rises on the edge that writes (5,5). Set state=11 -> arrived stays 1, further keys ignored. Set state=01 -> position (1,1), arrived=0, move_cnt=0.
- Start a move, drop state to 01 during WAIT -> no position update, no count, busy=0 next cycle. Repeat with rst_sys=1 during WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/maze_player_mover.sv
// maze_player_mover: turns direction key pulses into wall-checked player moves with exit detection
module maze_player_mover #(
  parameter int COORD_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_sys,
  input  logic [1:0]         state,
  input  logic [COORD_W-1:0] map_w,
  input  logic [COORD_W-1:0] map_h,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic               wall,
  output logic [COORD_W-1:0] my_x,
  output logic [COORD_W-1:0] my_y,
  output logic               arrived,
  output logic               busy,
  output logic [CNT_W-1:0]   move_cnt
);
  typedef enum logic {IDLE, WAIT} fsm_t;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO = COORD_W'(2);
  fsm_t fsm, fsm_n;
  logic play, up, dn, lf, rt, blocked, go, land;
  logic [COORD_W-1:0] tx, ty, x_n, y_n;
  logic [CNT_W-1:0] cnt_n;
  always_comb begin
    play = state == 2'b10;
    up = key_up;
    dn = !key_up && key_down;
    lf = !key_up && !key_down && key_left;
    rt = !key_up && !key_down && !key_left && key_right;
    tx = lf ? my_x - ONE : rt ? my_x + ONE : my_x;
    ty = up ? my_y - ONE : dn ? my_y + ONE : my_y;
    blocked = (up && my_y == '0) || (dn && my_y >= map_h - ONE) ||
              (lf && my_x == '0) || (rt && my_x >= map_w - ONE);
    go = play && fsm == IDLE && (up || dn || lf || rt) && !blocked;
    // rd_x/rd_y keep the target; the wall bit arrives in the second WAIT cycle
    land = play && fsm == WAIT && !rd_en && !wall;
    x_n = !state[1] ? ONE : land ? rd_x : my_x;
    y_n = !state[1] ? ONE : land ? rd_y : my_y;
    cnt_n = state == 2'b01 ? '0 : (land && !(&move_cnt)) ? move_cnt + CNT_W'(1) : move_cnt;
    fsm_n = (go || (play && fsm == WAIT && rd_en)) ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      fsm      <= IDLE;
      my_x     <= ONE;
      my_y     <= ONE;
      rd_en    <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      busy     <= 1'b0;
      arrived  <= 1'b0;
      move_cnt <= '0;
    end else begin
      fsm      <= fsm_n;
      my_x     <= x_n;
      my_y     <= y_n;
      rd_en    <= go;
      rd_x     <= go ? tx : rd_x;
      rd_y     <= go ? ty : rd_y;
      busy     <= fsm_n == WAIT;
      arrived  <= state[1] && x_n == map_w - TWO && y_n == map_h - TWO;
      move_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_maze_player_mover.sv
// tb_maze_player_mover: randomized scoreboard bench for the maze movement engine
module tb_maze_player_mover;
  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001;
  logic clk = 0, rst_sys = 1;
  logic [1:0] state = 2'b00;
  logic [8:0] map_w = 9'd7, map_h = 9'd7;
  logic key_up = 0, key_down = 0, key_left = 0, key_right = 0, wall = 0;
  logic rd_en, arrived, busy;
  logic [8:0] rd_x, rd_y, my_x, my_y;
  logic [15:0] move_cnt;

  maze_player_mover #(.COORD_W(9), .CNT_W(16)) dut (
    .clk(clk), .rst_sys(rst_sys), .state(state), .map_w(map_w), .map_h(map_h),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .wall(wall), .my_x(my_x), .my_y(my_y),
    .arrived(arrived), .busy(busy), .move_cnt(move_cnt));

  always #5 clk = ~clk;

  typedef struct {int x; int y;} rd_t;
  typedef struct {int x; int y; int c; int a;} pos_t;
  rd_t rd_q[$];
  pos_t pos_q[$];
  int checks = 0, errors = 0;
  int mx = 1, my = 1, cnt = 0, blen = 0;
  bit wall_next = 0, abort_flag = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // map RAM stand-in: answers the read one cycle later, noise otherwise
  always @(posedge clk) wall <= rd_en ? wall_next : ($urandom_range(0, 1) == 1);

  always @(negedge clk) begin
    rd_t r;
    pos_t p;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("unexpected_rd_en", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_x", rd_x, r.x);
        chk("rd_y", rd_y, r.y);
      end
    end
    if (busy) blen++;
    else if (blen != 0) begin
      if (abort_flag) abort_flag = 0;
      else begin
        chk("busy_len", blen, 2);
        if (pos_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          p = pos_q.pop_front();
          chk("my_x", my_x, p.x);
          chk("my_y", my_y, p.y);
          chk("move_cnt", move_cnt, p.c);
          chk("arrived", arrived, p.a);
        end
      end
      blen = 0;
    end
  end

  task automatic set_keys(input logic [3:0] m);
    {key_up, key_down, key_left, key_right} = m;
  endtask

  task automatic set_state(input logic [1:0] s);
    @(negedge clk);
    state = s;
    if (!s[1]) begin mx = 1; my = 1; end
    if (s == 2'b01) cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  // m2 is pulsed in the cycle after an accepted key and must be dropped
  task automatic press(input logic [3:0] m, input bit wv, input logic [3:0] m2);
    int tx, ty;
    bit ok;
    @(negedge clk);
    set_keys(m);
    wall_next = wv;
    tx = mx; ty = my;
    if (m[3]) ty = my - 1;
    else if (m[2]) ty = my + 1;
    else if (m[1]) tx = mx - 1;
    else if (m[0]) tx = mx + 1;
    ok = state == 2'b10 && m != 0 && tx >= 0 && tx < int'(map_w) && ty >= 0 && ty < int'(map_h);
    if (ok) begin
      rd_q.push_back('{tx, ty});
      if (!wv) begin
        mx = tx; my = ty;
        if (cnt < 65535) cnt++;
      end
      pos_q.push_back('{mx, my, cnt, int'(mx == int'(map_w) - 2 && my == int'(map_h) - 2)});
    end
    @(negedge clk);
    set_keys(ok ? m2 : 4'b0);
    @(negedge clk);
    set_keys(4'b0);
    repeat (2) @(negedge clk);
    if (!ok) begin
      chk("hold_x", my_x, mx);
      chk("hold_y", my_y, my);
      chk("hold_cnt", move_cnt, cnt);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", my_x, 1); chk("rst_y", my_y, 1); chk("rst_arrived", arrived, 0);
    chk("rst_busy", busy, 0); chk("rst_rd_en", rd_en, 0); chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_y", rd_y, 0); chk("rst_cnt", move_cnt, 0);
    rst_sys = 0;
    set_state(2'b01);
    chk("ready_x", my_x, 1); chk("ready_y", my_y, 1); chk("ready_cnt", move_cnt, 0);
    chk("ready_busy", busy, 0); chk("ready_arrived", arrived, 0);
    set_state(2'b10);
    press(DN, 1, 0);
    press(RT, 0, 0);
    press(UP, 0, 0);
    press(UP, 0, 0);
    press(DN, 0, 0);
    press(UP | LF, 0, RT);
    press(DN, 0, 0);
    while (mx < 6) press(RT, 0, 0);
    press(RT, 0, 0);
    press(LF, 0, 0);
    while (my < 5) press(DN, 0, 0);
    set_state(2'b11);
    chk("fin_arrived", arrived, 1);
    press(LF, 0, 0);
    press(UP, 0, 0);
    chk("fin_arrived_hold", arrived, 1);
    set_state(2'b01);
    chk("back_x", my_x, 1); chk("back_y", my_y, 1);
    chk("back_arrived", arrived, 0); chk("back_cnt", move_cnt, 0);
    set_state(2'b10);
    abort_flag = 1;
    @(negedge clk);
    set_keys(RT);
    rd_q.push_back('{mx + 1, my});
    @(negedge clk);
    set_keys(4'b0);
    state = 2'b01;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_x", my_x, 1); chk("abort_cnt", move_cnt, 0);
    set_state(2'b10);
    press(RT, 0, 0);
    abort_flag = 1;
    @(negedge clk);
    set_keys(RT);
    rd_q.push_back('{mx + 1, my});
    @(negedge clk);
    set_keys(4'b0);
    rst_sys = 1;
    @(negedge clk);
    chk("rabort_x", my_x, 1); chk("rabort_y", my_y, 1); chk("rabort_cnt", move_cnt, 0);
    chk("rabort_busy", busy, 0); chk("rabort_rd_en", rd_en, 0); chk("rabort_rd_x", rd_x, 0);
    chk("rabort_rd_y", rd_y, 0); chk("rabort_arrived", arrived, 0);
    rst_sys = 0;
    mx = 1; my = 1; cnt = 0;
    for (int r = 0; r < 4; r++) begin
      set_state(2'b01);
      map_w = 9'($urandom_range(3, 10));
      map_h = 9'($urandom_range(3, 10));
      set_state(2'b10);
      for (int i = 0; i < 40; i++)
        press(4'($urandom_range(1, 15)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 15)) : 4'b0);
    end
    repeat (4) @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("pos_q_drained", pos_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
